// File: rtl/fpu_pkg.sv
// Shared FPU conversion constants and request field widths.
// Imported by the request queue and the converter.
package fpu_pkg;

    localparam logic FCVT_F2I = 1'b0;
    localparam logic FCVT_I2F = 1'b1;

    localparam int unsigned FCVT_A_W    = 32;
    localparam int unsigned FCVT_SGN_W  = 1;
    localparam int unsigned FCVT_TYPE_W = 1;

    function automatic int unsigned fcvt_req_w(int unsigned tag_w);
        return FCVT_A_W + FCVT_SGN_W + FCVT_TYPE_W + tag_w;
    endfunction

endpackage

// File: rtl/fcvt_xx.sv
// Combinational FP32 <-> 32-bit integer converter.
// F2I truncates toward zero and saturates; I2F rounds to nearest even.
module fcvt_xx
    import fpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic        signed_i,
    input  logic        conv_type_i,
    output logic [31:0] result_o
);

    logic        f_sign;
    logic [7:0]  f_exp;
    logic [23:0] f_man;
    logic        f_nan;
    logic        f_small;
    logic        f_big;
    logic [4:0]  f_sh;
    logic [54:0] f_wide;
    logic [31:0] f_mag;
    logic [31:0] f2i_res;

    logic        i_neg;
    logic [31:0] i_mag;
    logic [4:0]  i_lz;
    logic [30:0] i_frac;
    logic [7:0]  i_exp;
    logic        i_rnd;
    logic [30:0] i_body;
    logic [31:0] i2f_res;

    assign f_sign  = a_i[31];
    assign f_exp   = a_i[30:23];
    assign f_man   = {1'b1, a_i[22:0]};
    assign f_nan   = (f_exp == 8'hFF) && (a_i[22:0] != 23'd0);
    assign f_small = f_exp < 8'd127;
    assign f_big   = f_exp > 8'd158;
    assign f_sh    = 5'(f_exp - 8'd127);
    assign f_wide  = {31'd0, f_man} << f_sh;
    assign f_mag   = 32'(f_wide >> 23);

    // FP32 -> integer with saturation on overflow, NaN and negative-to-unsigned
    always_comb begin
        f2i_res = '0;
        if (f_nan) begin
            f2i_res = signed_i ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        end else if (f_small) begin
            f2i_res = '0;
        end else if (signed_i) begin
            if (f_sign) begin
                f2i_res = (f_big || f_mag > 32'h8000_0000)
                        ? 32'h8000_0000 : (~f_mag + 32'd1);
            end else begin
                f2i_res = (f_big || f_mag > 32'h7FFF_FFFF)
                        ? 32'h7FFF_FFFF : f_mag;
            end
        end else begin
            if (f_sign) begin
                f2i_res = '0;
            end else begin
                f2i_res = f_big ? 32'hFFFF_FFFF : f_mag;
            end
        end
    end

    assign i_neg = signed_i & a_i[31];
    assign i_mag = i_neg ? (~a_i + 32'd1) : a_i;

    // Leading-zero count of the integer magnitude
    always_comb begin
        i_lz = '0;
        for (int i = 0; i < 32; i++) begin
            if (i_mag[i]) begin
                i_lz = 5'(31 - i);
            end
        end
    end

    assign i_frac = 31'(i_mag << i_lz);
    assign i_exp  = 8'd158 - {3'd0, i_lz};
    assign i_rnd  = i_frac[7] & ((|i_frac[6:0]) | i_frac[8]);
    assign i_body = {i_exp, i_frac[30:8]} + 31'(i_rnd);

    // Integer -> FP32; mantissa carry-out rolls into the exponent
    always_comb begin
        i2f_res = '0;
        if (i_mag != 32'd0) begin
            i2f_res = {i_neg, i_body};
        end
    end

    assign result_o = (conv_type_i == FCVT_I2F) ? i2f_res : f2i_res;

endmodule

// File: rtl/fcvt_req_queue.sv
// Request FIFO feeding one fcvt_xx, with a registered result stage.
// Accept and result sides are independent valid/ready handshakes.
module fcvt_req_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_a_i,
    input  logic             req_signed_i,
    input  logic             req_conv_type_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned REQ_W = fcvt_req_w(TAG_W);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [REQ_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic             push;
    logic             pop;
    logic [REQ_W-1:0] head;
    logic [31:0]      head_a;
    logic             head_sgn;
    logic             head_typ;
    logic [TAG_W-1:0] head_tag;
    logic [31:0]      cvt_res;

    assign req_ready_o = (count_q != FULL);
    assign push        = req_valid_i & req_ready_o;
    assign pop         = (count_q != '0) & (~rsp_valid_q | rsp_ready_i);

    assign head     = mem_q[rd_ptr_q];
    assign head_a   = head[REQ_W-1 -: 32];
    assign head_sgn = head[TAG_W+1];
    assign head_typ = head[TAG_W];
    assign head_tag = head[TAG_W-1:0];

    fcvt_xx u_fcvt (
        .a_i         (head_a),
        .signed_i    (head_sgn),
        .conv_type_i (head_typ),
        .result_o    (cvt_res)
    );

    // FIFO storage; a flushed cycle never writes
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= {req_a_i, req_signed_i, req_conv_type_i, req_tag_i};
        end
    end

    // Pointer and occupancy update; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Result register: load on pop, drop on handshake or flush
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        if (flush_i) begin
            rsp_valid_d = 1'b0;
        end else if (pop) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = cvt_res;
            rsp_tag_d    = head_tag;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Control and result state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign busy_o       = (count_q != '0) | rsp_valid_q;

endmodule
